// File: rtl/softmax_row_sched.sv
// softmax_row_sched: runs the tiled softmax core over a batch of rows.
// Each row gets a start pulse. Its score tiles are read from the score buffer and
// streamed into the core. The core's result tiles are written to the output buffer.
`timescale 1ns/1ps
module softmax_row_sched #(
    parameter int WIDTH          = 32,
    parameter int TOTAL_ELEMENTS = 16,
    parameter int TILE_SIZE      = 4,
    parameter int TILE_GAP       = 1,
    parameter int ROW_W          = 8,
    parameter int ADDR_W         = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ROW_W-1:0]            cmd_rows,
    input  logic [ADDR_W-1:0]           cmd_src,
    input  logic [ADDR_W-1:0]           cmd_dst,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [TILE_SIZE*WIDTH-1:0]  rd_data,
    output logic                        sm_en,
    output logic                        sm_start,
    output logic [TILE_SIZE*WIDTH-1:0]  sm_tile,
    output logic                        sm_tile_valid,
    input  logic [TILE_SIZE*WIDTH-1:0]  sm_tile_out,
    input  logic                        sm_tile_out_valid,
    input  logic                        sm_done,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [TILE_SIZE*WIDTH-1:0]  wr_data,
    output logic                        busy,
    output logic [ROW_W-1:0]            rows_done,
    output logic                        all_done,
    output logic                        err
);
    localparam int TILES = TOTAL_ELEMENTS / TILE_SIZE;
    localparam int CNT_W = $clog2(TILES + 1);

    localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_TILE = CNT_W'(TILES - 1);
    localparam logic [CNT_W-1:0]  ALL_TILES = CNT_W'(TILES);
    localparam logic [ADDR_W-1:0] TILES_A   = ADDR_W'(TILES);
    localparam logic [ROW_W-1:0]  ONE_R     = ROW_W'(1);
    localparam logic              GAP_ON    = (TILE_GAP != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]        r_state;
    logic [ROW_W-1:0]  r_rows;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W-1:0]  r_rows_done;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_row_base;   // row*TILES, kept as a running sum
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic              r_gap;
    logic              r_err;
    logic              r_rd_vld_p1;  // read strobe aligned with returning rd_data

    logic              w_wb_act;
    logic              w_tile_acc;
    logic              w_tile_ovf;
    logic              w_done;
    logic              w_short;
    logic              w_last_row;
    logic              w_rd_en;
    logic [CNT_W-1:0]  w_cnt_after;

    // Result tiles are accepted from START through DRAIN; a tile beyond TILES is dropped.
    assign w_wb_act    = (r_state == S_START) || (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_tile_acc  = w_wb_act && sm_tile_out_valid && (r_out_cnt != ALL_TILES);
    assign w_tile_ovf  = w_wb_act && sm_tile_out_valid && (r_out_cnt == ALL_TILES);
    assign w_done      = sm_done && ((r_state == S_FEED) || (r_state == S_DRAIN));
    // A tile that arrives with sm_done still counts toward the row before the short check.
    assign w_cnt_after = w_tile_acc ? (r_out_cnt + ONE_C) : r_out_cnt;
    assign w_short     = (w_cnt_after < ALL_TILES);
    assign w_last_row  = ((r_row + ONE_R) == r_rows);
    assign w_rd_en     = (r_state == S_FEED) && !r_gap;

    assign cmd_ready     = rst_n && (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign sm_en         = busy;
    assign sm_start      = (r_state == S_START);
    assign rd_en         = w_rd_en;
    assign rd_addr       = w_rd_en ? (r_src + r_row_base + ADDR_W'(r_in_cnt)) : '0;
    assign sm_tile_valid = r_rd_vld_p1;
    assign sm_tile       = r_rd_vld_p1 ? rd_data : '0;
    assign wr_en         = w_tile_acc;
    assign wr_addr       = w_tile_acc ? (r_dst + r_row_base + ADDR_W'(r_out_cnt)) : '0;
    assign wr_data       = w_tile_acc ? sm_tile_out : '0;
    assign rows_done     = r_rows_done;
    assign all_done      = (r_state == S_FINISH);
    assign err           = r_err;

    // Row sequencing, tile read issue, result counting and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rows      <= '0;
            r_row       <= '0;
            r_rows_done <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_row_base  <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_gap       <= 1'b0;
            r_err       <= 1'b0;
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_rd_en;
            if (w_tile_acc) r_out_cnt <= r_out_cnt + ONE_C;
            if (w_tile_ovf) r_err <= 1'b1;

            if (w_done) begin
                // Row complete: advance and re-arm counters for the next row's START.
                if (w_short) r_err <= 1'b1;
                r_rows_done <= r_rows_done + ONE_R;
                r_row       <= r_row + ONE_R;
                r_row_base  <= r_row_base + TILES_A;
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_gap       <= 1'b0;
                r_state     <= w_last_row ? S_FINISH : S_START;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            r_rows      <= cmd_rows;
                            r_src       <= cmd_src;
                            r_dst       <= cmd_dst;
                            r_rows_done <= '0;
                            r_err       <= 1'b0;
                            r_row       <= '0;
                            r_row_base  <= '0;
                            r_in_cnt    <= '0;
                            r_out_cnt   <= '0;
                            r_gap       <= 1'b0;
                            r_state     <= (cmd_rows == '0) ? S_FINISH : S_START;
                        end
                    end
                    S_START: r_state <= S_FEED;
                    S_FEED: begin
                        if (w_rd_en) begin
                            r_in_cnt <= r_in_cnt + ONE_C;
                            if (r_in_cnt == LAST_TILE) r_state <= S_DRAIN;
                            else                        r_gap   <= GAP_ON;
                        end else begin
                            r_gap <= 1'b0;
                        end
                    end
                    S_DRAIN:  r_state <= S_DRAIN;
                    S_FINISH: r_state <= S_IDLE;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/softmax_row_sched.md
# softmax_row_sched

Controller that runs the tiled softmax datapath `softmax_vec` over a batch of rows, for example attention score rows. It accepts a command with a row count and source/destination tile base addresses. For each row it pulses `softmax_vec` start, streams the row's tiles from a score buffer into it, and writes the returned probability tiles to an output buffer. It sits between the attention score memory and the softmax core and is the only master of that core.

## Interface
- WIDTH, 32, element width (Q16.16 fixed point, passed through untouched)
- TOTAL_ELEMENTS, 16, elements per row
- TILE_SIZE, 4, elements per tile; TILES = TOTAL_ELEMENTS/TILE_SIZE (integer, ≥1)
- TILE_GAP, 1, idle cycles inserted between consecutive input tiles (0 or 1)
- ROW_W, 8, width of the row count
- ADDR_W, 12, tile-address width of both buffers

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_rows  in  ROW_W  rows to process; 0 is legal
- cmd_src  in  ADDR_W  source tile base
- cmd_dst  in  ADDR_W  destination tile base
- rd_en  out  1  score buffer read strobe
- rd_addr  out  ADDR_W  score buffer tile address
- rd_data  in  TILE_SIZE*WIDTH  read data, valid exactly 1 cycle after rd_en
- sm_en  out  1  softmax enable; high whenever not IDLE
- sm_start  out  1  one-cycle start pulse per row
- sm_tile  out  TILE_SIZE*WIDTH  equals rd_data
- sm_tile_valid  out  1  rd_en delayed by 1 cycle
- sm_tile_out  in  TILE_SIZE*WIDTH  result tile
- sm_tile_out_valid  in  1  result tile strobe
- sm_done  in  1  row complete pulse
- wr_en  out  1  output buffer write strobe
- wr_addr  out  ADDR_W  output buffer tile address
- wr_data  out  TILE_SIZE*WIDTH  result tile
- busy  out  1  not IDLE
- rows_done  out  ROW_W  rows completed in the current command
- all_done  out  1  one-cycle pulse at command end
- err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, START, FEED, DRAIN, FINISH.
- IDLE: cmd_ready=1. On cmd_valid, latch rows/src/dst, clear rows_done and err, and set row=0. Go to FINISH if cmd_rows==0, otherwise to START.
- START: sm_start=1 for one cycle, clear in_cnt and out_cnt, then go to FEED.
- FEED: issue TILES reads at rd_addr = src + row*TILES + in_cnt, with TILE_GAP idle cycles between reads. After the last read, go to DRAIN.
- Writeback runs independently of state, from START through DRAIN. Each sm_tile_out_valid produces, in the same cycle, wr_en=1, wr_data=sm_tile_out and wr_addr = dst + row*TILES + out_cnt, then out_cnt increments.
- DRAIN: wait for sm_done.
  - If sm_done arrives with the last tile in the same cycle, that tile is still written first.
  - On sm_done: rows_done++ and row++. Go to FINISH if row==rows, otherwise to START.
- sm_done arriving outside FEED/DRAIN is ignored.
- FINISH: all_done=1 for one cycle, then go to IDLE.
- Errors, each sets err:
  - sm_tile_out_valid when out_cnt==TILES: no write, err=1.
  - sm_done while out_cnt<TILES (after counting any same-cycle tile): err=1, row still advances.
- Address arithmetic wraps modulo 2^ADDR_W. row*TILES is computed as a running base (add TILES per row), not with a multiplier.

## Timing
- Reset values: cmd_ready=0 while rst_n=0, then 1 in IDLE. All other outputs are 0. Reset mid-command abandons the row immediately with no further writes.
- Command accepted on edge T. sm_start is high in cycle T+1. First rd_en is in T+2, first sm_tile_valid in T+3.
- With TILE_GAP=1, rd_en is high in T+2, T+4, … T+2·TILES.
- Next row: sm_start is high the cycle after sm_done.
- all_done: high the cycle after the final sm_done; for rows==0, the cycle after acceptance.
- cmd_valid outside IDLE is ignored; cmd_ready=0 throughout.

## Test plan
- rows=1, TILES=4, src=0x010, dst=0x100, model core echoes tiles then pulses done: rd_addr 0x010..0x013 → wr_addr 0x100..0x103, data identical, rows_done=1, one all_done, err=0.
- rows=3, src=0x020, dst=0x200: reads 0x020..0x02B, writes 0x200..0x20B, three sm_start pulses each one cycle after the prior sm_done, rows_done=3.
- rows=0: all_done exactly one cycle after acceptance; no rd_en, sm_start or wr_en.
- Model emits 5 result tiles for one row: 4 writes, 5th dropped, err=1; next command clears err.
- sm_done with the last tile in the same cycle: write occurs and row advances in the same cycle; early sm_done after 2 tiles → err=1.
- rst_n low in the middle of FEED on row 1: all outputs are 0 immediately. After release cmd_ready=1, and a new rows=1 command completes normally.
- src=0xFFE, TILES=4: rd_addr sequence is 0xFFE, 0xFFF, 0x000, 0x001.
